// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the FIFO push arbiter
// Contents:
//   arb_state_e  arbiter FSM state (ARB_IDLE, ARB_GRANT)
//   ptr_w()      width of the round-robin pointer / owner index for n_req requesters
//   cnt_w()      width of the burst counter for a given max_burst
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // PTR_W = $clog2(n_req); kept at least 1 so a degenerate instance still elaborates
  function automatic int ptr_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // CNT_W = $clog2(max_burst+1); wide enough to hold max_burst
  function automatic int cnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rtl/fifo_push_arbiter_rr_pick.sv - combinational round-robin winner search
// Ports:
//   req     in   n_req   request vector
//   rr_ptr  in   PTR_W   highest-priority requester index
//   any     out  1       at least one request is set
//   winner  out  PTR_W   first set request searching rr_ptr, rr_ptr+1, ... mod n_req
import fifo_arb_pkg::*;

module rr_pick #(
  parameter int n_req = 4,
  localparam int PTR_W = ptr_w(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             any,
  output logic [PTR_W-1:0] winner
);

  function automatic logic [PTR_W-1:0] idx_of(input logic [PTR_W-1:0] ptr, input int k);
    int s;
    s = (int'(ptr) + k) % n_req;
    return PTR_W'(s);
  endfunction

  // Walk the offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    any    = |req;
    winner = '0;
    for (int k = n_req - 1; k >= 0; k--) begin
      if (req[idx_of(rr_ptr, k)]) winner = idx_of(rr_ptr, k);
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin burst arbiter for a single FIFO push port
// Ports:
//   clk        in   1            clock
//   rst        in   1            asynchronous active-low reset
//   req        in   n_req        per-requester word-available level
//   din_req    in   n_req*bits   flattened requester data, word i at [i*bits +: bits]
//   fifo_full  in   1            FIFO full flag
//   gnt        out  n_req        registered one-hot grant (zero in IDLE)
//   fifo_push  out  1            push strobe to the FIFO
//   fifo_din   out  bits         owner's data word, zero when not busy
//   busy       out  1            high while a grant is held
import fifo_arb_pkg::*;

module fifo_push_arbiter #(
  parameter int bits      = 8,
  parameter int n_req     = 4,
  parameter int max_burst = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [n_req-1:0]      req,
  input  logic [n_req*bits-1:0] din_req,
  input  logic                  fifo_full,
  output logic [n_req-1:0]      gnt,
  output logic                  fifo_push,
  output logic [bits-1:0]       fifo_din,
  output logic                  busy
);

  localparam int PTR_W = ptr_w(n_req);
  localparam int CNT_W = cnt_w(max_burst);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(max_burst - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(n_req - 1);

  arb_state_e       state_q, state_d;
  logic [n_req-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             pick_any;
  logic [PTR_W-1:0] pick_idx;
  logic             owner_req;
  logic             accept;

  rr_pick #(.n_req(n_req)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .winner (pick_idx)
  );

  assign busy      = (state_q == ARB_GRANT);
  assign owner_req = req[owner_q];
  // Full is sampled in the same cycle, so a rising full blocks this cycle's push.
  assign accept    = busy & owner_req & ~fifo_full;
  assign fifo_push = accept;
  assign fifo_din  = busy ? din_req[int'(owner_q)*bits +: bits] : '0;
  assign gnt       = gnt_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d           = ARB_GRANT;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          owner_d           = pick_idx;
          rr_ptr_d          = (pick_idx == LAST_IDX) ? '0 : pick_idx + PTR_W'(1);
          burst_cnt_d       = '0;
        end
      end
      ARB_GRANT: begin
        // Release on owner drop (including while stalled) or on the last word of a burst.
        if (!owner_req || (accept && burst_cnt_q == LAST_CNT)) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin write arbiter that shares the single push port of one `fifo` instance among `n_req` producers. It grants the FIFO to one requester at a time for a bounded burst of words and respects `fifo_full` back-pressure. It steers the granted requester's data onto `fifo_din`. It sits directly in front of the FIFO's `Din`/`push`/`full` pins.

## Interface
Parameters:
- `bits`, 8: data word width; must equal the FIFO `bits`.
- `n_req`, 4: number of requesters, ≥2.
- `max_burst`, 4: maximum words accepted per grant, ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  `n_req`  per-requester "word available" request; `req[i]` is level, not pulse.
- `din_req`  in  `n_req*bits`  flattened requester data; word i is `din_req[i*bits +: bits]`.
- `fifo_full`  in  1  FIFO full flag.
- `gnt`  out  `n_req`  one-hot (or zero) registered grant.
- `fifo_push`  out  1  push strobe to FIFO.
- `fifo_din`  out  `bits`  data to FIFO `Din`.
- `busy`  out  1  high while in GRANT state.

## Operation
- FSM states:
  - IDLE: no owner; `gnt` = 0.
  - GRANT: exactly one `gnt` bit set.
- Pointer `rr_ptr` has width `$clog2(n_req)` and names the highest-priority requester.
- **IDLE:** if `req != 0`, the winner is the first i with `req[i]` = 1, searching `rr_ptr`, `rr_ptr+1`, … modulo `n_req`. On the next edge:
  - `gnt[winner]` is set.
  - `rr_ptr` becomes `(winner+1) mod n_req`.
  - `burst_cnt` is cleared.
  - State goes to GRANT.
- **Accept condition** (combinational): `accept = busy & req[owner] & ~fifo_full`.
  - `fifo_push = accept`.
  - `fifo_din = din_req[owner]` when `busy`, else 0.
- The requester treats `gnt[i] & req[i] & ~fifo_full` as "word taken" and presents the next word or drops `req` by the following cycle.
- **GRANT:** on each accept, `burst_cnt` increments. The burst counter has width `$clog2(max_burst+1)`, counts accepts only and never wraps.
- **Release** to IDLE (`gnt` cleared on that edge) when either:
  - `req[owner]` = 0, or
  - an accept occurs with `burst_cnt == max_burst-1`.
- **Full stall:** `fifo_full` = 1 in GRANT gives no push and no count change, and the grant is held indefinitely. A requester dropping `req` while stalled releases the grant.
- Non-owner `req` changes have no effect during GRANT.
- **Reset:** any time, including mid-burst, reset forces state IDLE, `gnt` = 0, `rr_ptr` = 0 and `burst_cnt` = 0. Reset values of the outputs are `gnt` = 0, `busy` = 0, `fifo_push` = 0, `fifo_din` = 0.

## Timing
- Grant latency: `req` seen in IDLE at cycle t gives `gnt`/`busy` high in cycle t+1. The first push is possible in cycle t+1.
- A continuous burst of `max_burst` words pushes in consecutive cycles t+1 … t+`max_burst`. IDLE is in cycle t+`max_burst`+1, and the next grant is in cycle t+`max_burst`+2.
- Exactly one dead (IDLE) cycle separates consecutive grants.
- `fifo_push`/`fifo_din` are combinational from registered state plus `req`/`fifo_full`. There is no internal data register, so data reaches the FIFO in the same cycle.
- `fifo_full` is sampled every cycle. A full flag rising in the same cycle as a would-be accept blocks that accept.

## Structure
- Shared package `fifo_arb_pkg`:
  - state enum type (`ARB_IDLE`, `ARB_GRANT`);
  - helper constants `PTR_W = $clog2(n_req)` and `CNT_W = $clog2(max_burst+1)`, computed per instance from parameters.
- One combinational sub-module, `rr_pick`, with parameter `n_req`:
  - inputs `req` and `rr_ptr`;
  - outputs `any` and `winner` index.
- The top holds the FSM, `rr_ptr`, `burst_cnt`, the owner index register and the output mux.

## Test plan
- **Reset/idle:** assert `rst`=0, then release with `req`=0 → `gnt`=0, `busy`=0, `fifo_push`=0, `fifo_din`=0 for 5 cycles.
- **Single requester burst:** `req`=4'b0100 held, data 0xA0..0xA5 advancing on each accept, `fifo_full`=0 → pushes 0xA0–0xA3 in cycles 1–4, one IDLE cycle, regrant to requester 2 and push 0xA4 in cycle 6.
- **Round-robin fairness:** `req`=4'b1111 held, `max_burst`=1, starting after reset → `gnt` sequence 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
- **Back-pressure:** requester 1 granted, `fifo_full`=1 for 3 cycles mid-burst after 2 words → no push, `gnt` held, `burst_cnt`=2. After full drops, exactly 2 more pushes, then release.
- **Early release:** requester 3 granted, drops `req` after 1 word while `req[0]`=1 → IDLE next cycle, then `gnt`=4'b0001 (`rr_ptr` wrapped 3→0).
- **Reset mid-burst:** assert `rst` low during requester 2's second word → `gnt`=0 and `fifo_push`=0 immediately. After release with `req`=4'b0101, requester 0 wins (`rr_ptr`=0).
